// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register with load formatting, register-bank write port,
// forwarding tap and retired-instruction counter.
module writeback_stage #(
  parameter int XLEN = 64,
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic            mem_memtoreg,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [2:0]      mem_addr_lo,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_load_data,
  output logic [REGW-1:0] register3,
  output logic [XLEN-1:0] datain,
  output logic            regwrite,
  output logic            fwd_valid,
  output logic [REGW-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic [CNTW-1:0] retired_count
);
  logic            wb_valid;
  logic [REGW-1:0] wb_rd;
  logic            wb_regwrite;
  logic            wb_memtoreg;
  logic [1:0]      wb_size;
  logic            wb_unsigned;
  logic [2:0]      wb_addr_lo;
  logic [XLEN-1:0] wb_alu_result;
  logic [XLEN-1:0] wb_load_data;
  logic            commit;
  logic [7:0]      lb;
  logic [15:0]     lh;
  logic [31:0]     lw;
  logic [XLEN-1:0] load_fmt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_regwrite   <= 1'b0;
      wb_memtoreg   <= 1'b0;
      wb_size       <= '0;
      wb_unsigned   <= 1'b0;
      wb_addr_lo    <= '0;
      wb_alu_result <= '0;
      wb_load_data  <= '0;
      retired_count <= '0;
    end else begin
      if (flush) begin
        wb_valid <= 1'b0;
      end else if (!stall) begin
        wb_valid      <= mem_valid;
        wb_rd         <= mem_rd;
        wb_regwrite   <= mem_regwrite;
        wb_memtoreg   <= mem_memtoreg;
        wb_size       <= mem_size;
        wb_unsigned   <= mem_unsigned;
        wb_addr_lo    <= mem_addr_lo;
        wb_alu_result <= mem_alu_result;
        wb_load_data  <= mem_load_data;
      end
      if (commit) retired_count <= retired_count + CNTW'(1);
    end
  end
  // Lane select ignores the low address bits below the access size.
  always_comb begin
    lb = wb_load_data[{wb_addr_lo, 3'b000} +: 8];
    lh = wb_load_data[{wb_addr_lo[2:1], 4'b0000} +: 16];
    lw = wb_load_data[{wb_addr_lo[2], 5'b00000} +: 32];
    load_fmt = wb_size == 2'd0 ? {{(XLEN-8){~wb_unsigned & lb[7]}}, lb} :
               wb_size == 2'd1 ? {{(XLEN-16){~wb_unsigned & lh[15]}}, lh} :
               wb_size == 2'd2 ? {{(XLEN-32){~wb_unsigned & lw[31]}}, lw} :
                                 wb_load_data;
  end
  assign commit    = wb_valid & ~stall;
  assign regwrite  = commit & wb_regwrite & (wb_rd != '0);
  assign register3 = wb_rd;
  assign datain    = wb_memtoreg ? load_fmt : wb_alu_result;
  assign fwd_valid = regwrite;
  assign fwd_rd    = wb_rd;
  assign fwd_data  = datain;
endmodule
